mul_acc_collector: RTL and testbench

- Downstream stage of the 8-bit pipelined multiplier.
- Consumes the multiplier's enable-qualified 16-bit product stream.
- Sums each group of GROUP consecutive valid products into a saturating accumulator.
- Hands each group sum to the next stage through a single-entry, valid/ready output register.
- The multiplier has no backpressure, so a group that completes while the output register is still full is dropped and flagged.

---
 rtl/mul_acc_collector.sv | 91 +++++++++
 tb/tb_mul_acc_collector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mul_acc_collector.sv
// Collects GROUP consecutive enable-qualified products into a saturating sum.
// Each group sum goes to a single-entry valid/ready output register. A group that finds the register full is dropped and sets overrun.
module mul_acc_collector #(
  parameter int IN_W  = 16,
  parameter int GROUP = 4,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_en,
  input  logic [IN_W-1:0]  in_data,
  input  logic             clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic             overrun,
  output logic [7:0]       grp_cnt
);

  localparam logic [7:0] LAST_CNT = 8'(GROUP - 1);

  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [7:0]       cnt;

  logic [ACC_W-1:0] base;
  logic             sat_base;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_nxt;
  logic             sat_nxt;
  logic             last;
  logic             drain;
  logic             load;
  logic             drop;

  // A fresh group starts from zero even though acc still holds the previous sum.
  always_comb begin
    base     = (cnt == 8'd0) ? '0 : acc;
    sat_base = (cnt == 8'd0) ? 1'b0 : sat;
    sum_ext  = {1'b0, base} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
    acc_nxt  = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    sat_nxt  = sat_base | sum_ext[ACC_W];
    last     = in_en && (cnt == LAST_CNT);
    drain    = out_valid && out_ready;
    load     = last && (!out_valid || out_ready);
    drop     = last && out_valid && !out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      sat <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
      cnt <= '0;
    end else if (in_en) begin
      acc <= acc_nxt;
      sat <= sat_nxt;
      cnt <= last ? 8'd0 : cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_sum   <= acc_nxt;
        out_sat   <= sat_nxt;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  assign grp_cnt = cnt;

endmodule

// File: tb/tb_mul_acc_collector.sv
// Directed bench for mul_acc_collector: a GROUP=4 instance and a GROUP=8 instance share one input stream.
module tb_mul_acc_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_en = 1'b0;
  logic [15:0] in_data = '0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        out_valid_a, out_sat_a, overrun_a;
  logic [17:0] out_sum_a;
  logic [7:0]  grp_cnt_a;
  logic        out_valid_b, out_sat_b, overrun_b;
  logic [17:0] out_sum_b;
  logic [7:0]  grp_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_acc_collector #(.IN_W(16), .GROUP(4), .ACC_W(18)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_data(in_data), .clr(clr),
    .out_ready(out_ready), .out_valid(out_valid_a), .out_sum(out_sum_a),
    .out_sat(out_sat_a), .overrun(overrun_a), .grp_cnt(grp_cnt_a)
  );

  mul_acc_collector #(.IN_W(16), .GROUP(8), .ACC_W(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_data(in_data), .clr(clr),
    .out_ready(out_ready), .out_valid(out_valid_b), .out_sum(out_sum_b),
    .out_sat(out_sat_b), .overrun(overrun_b), .grp_cnt(grp_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic en, input logic [15:0] data, input logic c);
    @(negedge clk);
    in_en   = en;
    in_data = data;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(out_valid_a), 0);
    chk("rst_sum", 32'(out_sum_a), 0);
    chk("rst_sat", 32'(out_sat_a), 0);
    chk("rst_overrun", 32'(overrun_a), 0);
    chk("rst_cnt", 32'(grp_cnt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic group
    out_ready = 1'b1;
    step(1, 3, 0); chk("basic_cnt1", 32'(grp_cnt_a), 1);
    chk("basic_novalid", 32'(out_valid_a), 0);
    step(1, 5, 0); chk("basic_cnt2", 32'(grp_cnt_a), 2);
    step(1, 7, 0); chk("basic_cnt3", 32'(grp_cnt_a), 3);
    step(1, 9, 0);
    chk("basic_valid", 32'(out_valid_a), 1);
    chk("basic_sum", 32'(out_sum_a), 24);
    chk("basic_sat", 32'(out_sat_a), 0);
    chk("basic_cnt0", 32'(grp_cnt_a), 0);
    step(0, 0, 0); chk("basic_pulse", 32'(out_valid_a), 0);

    // gaps
    step(1, 3, 0); chk("gap_cnt1", 32'(grp_cnt_a), 1);
    step(0, 16'hffff, 0); chk("gap_hold1", 32'(grp_cnt_a), 1);
    step(1, 5, 0); chk("gap_cnt2", 32'(grp_cnt_a), 2);
    step(0, 0, 0); chk("gap_hold2", 32'(grp_cnt_a), 2);
    step(1, 7, 0); chk("gap_cnt3", 32'(grp_cnt_a), 3);
    step(0, 0, 0); chk("gap_hold3", 32'(grp_cnt_a), 3);
    chk("gap_novalid", 32'(out_valid_a), 0);
    step(1, 9, 0);
    chk("gap_valid", 32'(out_valid_a), 1);
    chk("gap_sum", 32'(out_sum_a), 24);
    chk("gap_cnt0", 32'(grp_cnt_a), 0);
    step(0, 0, 0); chk("gap_pulse", 32'(out_valid_a), 0);

    // backpressure and overrun
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("bp_valid", 32'(out_valid_a), 1);
    chk("bp_sum", 32'(out_sum_a), 4);
    step(0, 0, 0);
    chk("bp_hold", 32'(out_valid_a), 1);
    chk("bp_no_overrun", 32'(overrun_a), 0);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    chk("bp_no_overrun3", 32'(overrun_a), 0);
    step(1, 1, 0);
    chk("bp_overrun", 32'(overrun_a), 1);
    chk("bp_kept_sum", 32'(out_sum_a), 4);
    chk("bp_kept_valid", 32'(out_valid_a), 1);
    out_ready = 1'b1;
    step(0, 0, 0);
    chk("bp_drained", 32'(out_valid_a), 0);
    chk("bp_overrun_sticky", 32'(overrun_a), 1);

    // clear, then drain and load in the same cycle
    out_ready = 1'b0;
    step(0, 0, 1);
    chk("clr_overrun", 32'(overrun_a), 0);
    chk("clr_valid", 32'(out_valid_a), 0);
    step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(1, 4, 0);
    chk("dl_pending_valid", 32'(out_valid_a), 1);
    chk("dl_pending_sum", 32'(out_sum_a), 10);
    step(1, 5, 0); step(1, 5, 0); step(1, 5, 0);
    chk("dl_held_sum", 32'(out_sum_a), 10);
    out_ready = 1'b1;
    step(1, 5, 0);
    chk("dl_valid", 32'(out_valid_a), 1);
    chk("dl_sum", 32'(out_sum_a), 20);
    chk("dl_overrun", 32'(overrun_a), 0);
    step(0, 0, 0);
    chk("dl_drained", 32'(out_valid_a), 0);

    // saturation on the GROUP=8 instance
    step(0, 0, 1);
    chk("sat_clr_cnt_b", 32'(grp_cnt_b), 0);
    for (int i = 0; i < 4; i++) step(1, 16'd65025, 0);
    chk("sat_a_sum", 32'(out_sum_a), 260100);
    chk("sat_a_flag", 32'(out_sat_a), 0);
    chk("sat_b_cnt", 32'(grp_cnt_b), 4);
    for (int i = 0; i < 4; i++) step(1, 16'd65025, 0);
    chk("sat_b_valid", 32'(out_valid_b), 1);
    chk("sat_b_sum", 32'(out_sum_b), 262143);
    chk("sat_b_flag", 32'(out_sat_b), 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("after_sat_a_sum", 32'(out_sum_a), 4);
    chk("after_sat_a_flag", 32'(out_sat_a), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("after_sat_b_sum", 32'(out_sum_b), 8);
    chk("after_sat_b_flag", 32'(out_sat_b), 0);

    // clear mid-group; the product presented with clr is lost
    step(1, 100, 0); step(1, 200, 0);
    chk("mid_cnt2", 32'(grp_cnt_a), 2);
    step(1, 999, 1);
    chk("mid_clr_cnt", 32'(grp_cnt_a), 0);
    chk("mid_clr_valid", 32'(out_valid_a), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("mid_clr_sum", 32'(out_sum_a), 4);
    chk("mid_clr_valid2", 32'(out_valid_a), 1);

    // asynchronous reset mid-group with a full output register
    out_ready = 1'b0;
    step(1, 100, 0); step(1, 200, 0);
    chk("rst_mid_cnt", 32'(grp_cnt_a), 2);
    chk("rst_mid_full", 32'(out_valid_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_a), 0);
    chk("arst_sum", 32'(out_sum_a), 0);
    chk("arst_cnt", 32'(grp_cnt_a), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    in_en  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("rst_mid_sum", 32'(out_sum_a), 4);
    chk("rst_mid_valid", 32'(out_valid_a), 1);
    chk("rst_mid_sat", 32'(out_sat_a), 0);
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
